// File: rtl/rmii_rx_framer_if.sv
// RMII receive framer bus: PHY dibit inputs and byte/frame-status outputs.
interface rmii_rx_framer_if;
  logic        rmii_crs_dv_i;
  logic [1:0]  rmii_rxd_i;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        sof_o;
  logic        eof_o;
  logic [10:0] len_o;
  logic        crc_ok_o;
  logic [2:0]  err_o;

  // PHY / stimulus side
  modport master (
    output rmii_crs_dv_i, rmii_rxd_i,
    input  data_o, valid_o, sof_o, eof_o, len_o, crc_ok_o, err_o
  );

  // Framer side
  modport slave (
    input  rmii_crs_dv_i, rmii_rxd_i,
    output data_o, valid_o, sof_o, eof_o, len_o, crc_ok_o, err_o
  );
endinterface

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: preamble/SFD hunt, dibit-to-byte assembly, CRC-32
// residue check and runt/giant/alignment status reported on a one-cycle eof.
module rmii_rx_framer #(
  parameter int MIN_FRAME_BYTES = 64,
  parameter int MAX_FRAME_BYTES = 1518
) (
  input  logic            clk_i,
  input  logic            rst_i,
  rmii_rx_framer_if.slave bus
);

  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;  // 0x04C11DB7 reflected
  // Residue of the reflected register over data+FCS. This is the bit-reversed
  // form of the textbook 0xC704DD7B residue.
  localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;
  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_BYTES);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME_BYTES);

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  k_q;
  logic [7:0]  sr_q;
  logic [10:0] cnt_q;
  logic [31:0] crc_q;
  logic        giant_q;

  logic        crs;
  logic [1:0]  rxd;
  logic [7:0]  byte_w;
  logic        sfd, shift, emit, giant, end_data, end_drop;

  assign crs = bus.rmii_crs_dv_i;
  assign rxd = bus.rmii_rxd_i;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    return r;
  endfunction

  // Byte under assembly with the current dibit merged at position k.
  always_comb begin
    byte_w = sr_q;
    byte_w[{k_q, 1'b0} +: 2] = rxd;
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle datapath strobes.
  always_comb begin
    state_d  = state_q;
    sfd      = 1'b0;
    shift    = 1'b0;
    emit     = 1'b0;
    giant    = 1'b0;
    end_data = 1'b0;
    end_drop = 1'b0;
    case (state_q)
      IDLE: if (crs && rxd == 2'b01) state_d = PREAMBLE;
      PREAMBLE: begin
        if (!crs)               state_d = IDLE;
        else if (rxd == 2'b11) begin
          state_d = DATA;
          sfd     = 1'b1;
        end
        else if (rxd != 2'b01) state_d = DROP;
      end
      DATA: begin
        if (!crs) begin
          end_data = 1'b1;
          state_d  = IDLE;
        end else begin
          shift = 1'b1;
          if (k_q == 2'd3) begin
            if (cnt_q == MAX_LEN) begin
              giant   = 1'b1;
              state_d = DROP;
            end else begin
              emit = 1'b1;
            end
          end
        end
      end
      DROP: begin
        if (!crs) begin
          end_drop = giant_q;  // only a giant drop reports eof
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Assembly, CRC, byte counter and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      k_q          <= '0;
      sr_q         <= '0;
      cnt_q        <= '0;
      crc_q        <= CRC_INIT;
      giant_q      <= 1'b0;
      bus.data_o   <= '0;
      bus.valid_o  <= 1'b0;
      bus.sof_o    <= 1'b0;
      bus.eof_o    <= 1'b0;
      bus.len_o    <= '0;
      bus.crc_ok_o <= 1'b0;
      bus.err_o    <= '0;
    end else begin
      bus.valid_o <= emit;
      bus.sof_o   <= emit && cnt_q == 11'd0;
      bus.eof_o   <= end_data || end_drop;
      if (state_q == IDLE) giant_q <= 1'b0;
      if (sfd) begin
        k_q   <= '0;
        sr_q  <= '0;
        cnt_q <= '0;
        crc_q <= CRC_INIT;
      end
      if (shift) begin
        k_q  <= k_q + 2'd1;
        sr_q <= byte_w;
      end
      if (emit) begin
        bus.data_o <= byte_w;
        cnt_q      <= cnt_q + 11'd1;
        crc_q      <= crc_byte(crc_q, byte_w);
      end
      if (giant) giant_q <= 1'b1;
      if (end_data) begin
        bus.len_o    <= cnt_q;
        bus.crc_ok_o <= crc_q == CRC_RES;
        bus.err_o    <= {1'b0, cnt_q < MIN_LEN, k_q != 2'd0};
      end
      if (end_drop) begin
        bus.len_o    <= MAX_LEN;
        bus.crc_ok_o <= 1'b0;
        bus.err_o    <= 3'b100;
      end
    end
  end

endmodule
